// File: rtl/present_sbox_3sh_pipe.sv
// Three-share masked PRESENT S-box layer: NSBOX 4-bit lanes, registered component
// functions, share compression with fresh-random refresh, and a two-stage valid/ready pipe.

// Component functions of one lane. cf[9*b + 3*i + j] is term (i,j) of output bit b.
// Share pair (i,j) picks the first two operands of each monomial, so the nine terms
// of a bit XOR to the unmasked S-box bit.
module nf_cf_1 (
  input  logic [2:0]  a,
  input  logic [2:0]  b,
  input  logic [2:0]  c,
  input  logic [2:0]  d,
  output logic [35:0] cf
);
  logic [3:0] xs [3];
  logic [3:0] xf;

  assign xs[0] = {d[0], c[0], b[0], a[0]};
  assign xs[1] = {d[1], c[1], b[1], a[1]};
  assign xs[2] = {d[2], c[2], b[2], a[2]};
  assign xf    = xs[0] ^ xs[1] ^ xs[2];

  always_comb begin
    logic [3:0] u, v, lin;
    logic       cst;
    cf = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        u   = xs[i];
        v   = xs[j];
        lin = (i == j) ? u : 4'h0;
        cst = (i == 0) && (j == 0);
        // ANF of PRESENT S, bit 0 = LSB; cubic monomials take the recombined third operand
        cf[3*i + j]      = lin[0] ^ lin[2] ^ lin[3] ^ (u[1] & v[2]);
        cf[9 + 3*i + j]  = lin[1] ^ lin[3] ^ (u[0] & v[1] & xf[2]) ^ (u[1] & v[3])
                         ^ (u[0] & v[1] & xf[3]) ^ (u[2] & v[3]) ^ (u[0] & v[2] & xf[3]);
        cf[18 + 3*i + j] = cst ^ lin[2] ^ lin[3] ^ (u[0] & v[1]) ^ (u[0] & v[3]) ^ (u[1] & v[3])
                         ^ (u[0] & v[1] & xf[3]) ^ (u[0] & v[2] & xf[3]);
        cf[27 + 3*i + j] = cst ^ lin[0] ^ lin[1] ^ lin[3] ^ (u[1] & v[2]) ^ (u[0] & v[1] & xf[2])
                         ^ (u[0] & v[1] & xf[3]) ^ (u[0] & v[2] & xf[3]);
      end
    end
  end
endmodule

module present_sbox_3sh_pipe #(
  parameter int NSBOX      = 16,
  parameter int R_AT_INPUT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NSBOX-1:0]   in1,
  input  logic [4*NSBOX-1:0]   in2,
  input  logic [4*NSBOX-1:0]   in3,
  input  logic [8*NSBOX-1:0]   r,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NSBOX-1:0]   out1,
  output logic [4*NSBOX-1:0]   out2,
  output logic [4*NSBOX-1:0]   out3
);
  localparam int W   = 4 * NSBOX;
  localparam int CFW = 36 * NSBOX;
  localparam int RW  = 8 * NSBOX;

  logic [CFW-1:0] cf_w, cf_reg;
  logic [RW-1:0]  r_src;
  logic [W-1:0]   n1, n2, n3;
  logic           s1_v, s1_adv, s2_adv, accept, s2_load;

  // Handshake: a beat moves on a rising edge when valid && ready; a stage may take a new
  // beat when empty or when its successor advances; flush drops both stages and any input.
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv;
  assign accept   = in_valid && in_ready && !flush;
  assign s2_load  = s1_v && s2_adv && !flush;

  for (genvar k = 0; k < NSBOX; k++) begin : g_lane
    nf_cf_1 u_cf (
      .a  ({in3[4*k],   in2[4*k],   in1[4*k]}),
      .b  ({in3[4*k+1], in2[4*k+1], in1[4*k+1]}),
      .c  ({in3[4*k+2], in2[4*k+2], in1[4*k+2]}),
      .d  ({in3[4*k+3], in2[4*k+3], in1[4*k+3]}),
      .cf (cf_w[36*k +: 36])
    );
  end

  if (R_AT_INPUT != 0) begin : g_r_in
    logic [RW-1:0] r_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_reg <= '0;
      else if (accept) r_reg <= r;
    end
    assign r_src = r_reg;
  end else begin : g_r_live
    assign r_src = r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      cf_reg <= '0;
    end else begin
      if (flush)       s1_v <= 1'b0;
      else if (s1_adv) s1_v <= in_valid;
      if (accept) cf_reg <= cf_w;
    end
  end

  always_comb begin
    logic q1, q2, q3, ra, rb;
    int   t, p;
    n1 = '0;
    n2 = '0;
    n3 = '0;
    for (int k = 0; k < NSBOX; k++) begin
      for (int b = 0; b < 4; b++) begin
        t  = 36*k + 9*b;
        p  = (b + 2) % 4;
        q1 = cf_reg[t]   ^ cf_reg[t+1] ^ cf_reg[t+2];
        q2 = cf_reg[t+3] ^ cf_reg[t+4] ^ cf_reg[t+5];
        q3 = cf_reg[t+6] ^ cf_reg[t+7] ^ cf_reg[t+8];
        ra = r_src[8*k + 2*p];
        rb = r_src[8*k + 2*p + 1];
        n1[4*k + b] = q1 ^ ra;
        n2[4*k + b] = q2 ^ rb;
        n3[4*k + b] = q3 ^ ra ^ rb;
      end
    end
  end

  // Data registers are never cleared on drain so shares do not recombine on the wires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out1      <= '0;
      out2      <= '0;
      out3      <= '0;
    end else begin
      if (flush)       out_valid <= 1'b0;
      else if (s2_adv) out_valid <= s1_v;
      if (s2_load) begin
        out1 <= n1;
        out2 <= n2;
        out3 <= n3;
      end
    end
  end
endmodule
